// File: rtl/lcd4_stream_writer.sv
// lcd4_stream_writer: byte FIFO feeding an HD44780 in 4-bit mode, with power-up init and automatic line wrap
module lcd4_stream_writer #(
  parameter int CLK_DIV    = 64,
  parameter int E_HIGH     = 1,
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_SLOTS  = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [7:0]                          in_data,
  input  logic                                in_cmd,
  output logic                                lcd_rs,
  output logic                                lcd_e,
  output logic [3:0]                          lcd_d,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = $clog2(COLS + 1);
  localparam int EW = $clog2(E_HIGH + 1);
  localparam int NW = $clog2(CLR_SLOTS + 6);

  typedef enum logic [2:0] {INIT, CLRWAIT, IDLE, HI, LO, WRAP_HI, WRAP_LO} state_t;
  state_t state;

  logic [PW-1:0] presc;
  logic          tick;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [8:0]    head, cur;
  logic [AW-1:0] wp, rp;
  logic          ready_r, push, pop;
  logic [NW-1:0] cnt;
  logic [CW-1:0] col;
  logic          row, row_next;
  logic [EW-1:0] ecnt;
  logic          send, send_rs;
  logic [3:0]    send_d, init_nib;

  assign tick     = presc == '0;
  assign head     = mem[rp];
  assign in_ready = ready_r && fifo_level != LW'(FIFO_DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = state == IDLE && tick && fifo_level != '0;
  assign busy     = state != IDLE || fifo_level != '0;
  assign row_next = ROWS == 2 ? ~row : 1'b0;
  // 4-bit mode, display on / cursor off, clear
  assign init_nib = cnt == NW'(0) ? 4'h3 : cnt == NW'(1) ? 4'h2 : cnt == NW'(3) ? 4'hC :
                    cnt == NW'(5) ? 4'h1 : 4'h0;
  assign send     = pop || (tick && (state == INIT || state == HI || state == WRAP_HI || state == WRAP_LO));
  assign send_rs  = state == IDLE ? ~head[8] : state == HI && ~cur[8];
  assign send_d   = state == INIT ? init_nib : state == IDLE ? head[7:4] : state == HI ? cur[3:0] :
                    state == WRAP_HI ? (row ? 4'hC : 4'h8) : 4'h0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc <= '0;
    else presc <= presc == PW'(CLK_DIV - 1) ? '0 : presc + 1'b1;

  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_cmd, in_data};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      ready_r    <= 1'b0;
    end else begin
      ready_r    <= 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lcd_rs <= 1'b0;
      lcd_d  <= '0;
      lcd_e  <= 1'b0;
      ecnt   <= '0;
    end else if (send) begin
      lcd_rs <= send_rs;
      lcd_d  <= send_d;
      lcd_e  <= 1'b1;
      ecnt   <= EW'(E_HIGH - 1);
    end else begin
      lcd_e  <= lcd_e && ecnt != '0;
      if (ecnt != '0) ecnt <= ecnt - 1'b1;
    end

  // LO lasts a single cycle: the byte is retired long before the next tick, so no slot is lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      col   <= '0;
      row   <= 1'b0;
      cur   <= '0;
    end else begin
      case (state)
        INIT: if (tick) begin
          cnt   <= cnt == NW'(5) ? '0 : cnt + 1'b1;
          state <= cnt == NW'(5) ? CLRWAIT : INIT;
        end
        CLRWAIT: if (tick) begin
          if (cnt == NW'(CLR_SLOTS - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            col   <= '0;
            row   <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        IDLE: if (pop) begin
          cur   <= head;
          state <= HI;
        end
        HI: if (tick) state <= LO;
        LO: begin
          if (cur[8]) begin
            if (cur[7:0] == 8'h01 || cur[7:0] == 8'h02) begin
              col <= '0;
              row <= 1'b0;
            end
            state <= IDLE;
          end else if (col == CW'(COLS - 1)) begin
            col   <= '0;
            row   <= row_next;
            state <= WRAP_HI;
          end else begin
            col   <= col + 1'b1;
            state <= IDLE;
          end
        end
        WRAP_HI: if (tick) state <= WRAP_LO;
        WRAP_LO: if (tick) state <= IDLE;
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_lcd4_stream_writer.sv
// tb_lcd4_stream_writer: directed vectors for the 4-bit LCD stream writer, strobes captured on lcd_e rise
module tb_lcd4_stream_writer;
  localparam int CLK_DIV = 8, E_HIGH = 2, COLS = 4, ROWS = 2, FIFO_DEPTH = 4, CLR_SLOTS = 2;

  logic       clk = 0, rst_n = 0, in_valid = 0, in_cmd = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, lcd_rs, lcd_e, busy;
  logic [3:0] lcd_d;
  logic [2:0] fifo_level;

  int ncmp = 0, nerr = 0, cyc = 0, hi = 0, c0 = 0;
  logic [7:0] cap[$];
  int         rise[$];

  typedef struct {
    int           n_in;
    logic [119:0] ins;
    int           n_exp;
    logic [191:0] exps;
  } vec_t;
  vec_t v[5];

  lcd4_stream_writer #(.CLK_DIV(CLK_DIV), .E_HIGH(E_HIGH), .COLS(COLS), .ROWS(ROWS),
                       .FIFO_DEPTH(FIFO_DEPTH), .CLR_SLOTS(CLR_SLOTS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cmd(in_cmd), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d), .busy(busy),
    .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // each strobe is logged as {rs, d} (0x14 = RS 1, D 4) with the cycle it rose
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) hi = 0;
    else if (lcd_e) begin
      if (hi == 0) begin
        cap.push_back({3'b000, lcd_rs, lcd_d});
        rise.push_back(cyc);
      end
      hi++;
    end else if (hi != 0) begin
      chk("e_width", hi, E_HIGH);
      hi = 0;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_e"}, lcd_e, 0);
    chk({tag, "_rs"}, lcd_rs, 0);
    chk({tag, "_d"}, lcd_d, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    repeat (3) @(negedge clk);
    cap.delete();
    rise.delete();
    #2 rst_n = 1;
    c0 = cyc;
  endtask

  task automatic wait_cap(input int n);
    int t = 0;
    while (cap.size() < n && t < 2000) begin @(negedge clk); #1; t++; end
    chk("cap_timeout", cap.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 4000) begin @(negedge clk); #1; t++; end
    chk("idle_timeout", busy, 0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [11:0] b);
    int t = 0;
    in_cmd = b[8];
    in_data = b[7:0];
    in_valid = 1;
    while (!in_ready && t < 2000) begin @(negedge clk); t++; end
    chk("push_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input int off, input int n, input logic [191:0] exps);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_nib%0d", tag, j), (off + j < cap.size()) ? 32'(cap[off + j]) : 32'hFFFF,
          32'(exps[8 * (n - 1 - j) +: 8]));
      if (j > 0 && off + j < rise.size())
        chk($sformatf("%s_gap%0d", tag, j), rise[off + j] - rise[off + j - 1], CLK_DIV);
    end
  endtask

  task automatic check_init(input bit chk_busy);
    int t = 0;
    wait_cap(6);
    check_seq("init", 0, 6, 48'h03_02_00_0C_00_01);
    if (rise.size() > 0) chk("init_start", rise[0] - c0, 1);
    if (chk_busy) begin
      while (busy && t < 2000) begin @(negedge clk); #1; t++; end
      if (rise.size() >= 6) chk("busy_fall", cyc - rise[5], CLR_SLOTS * CLK_DIV);
      repeat (3 * CLK_DIV) @(negedge clk);
      #1;
      chk("init_count", cap.size(), 6);
    end
  endtask

  initial begin
    v[0].n_in = 1; v[0].ins = 12'h048;
    v[0].n_exp = 2; v[0].exps = 16'h14_18;
    v[1].n_in = 6; v[1].ins = 72'h102_041_042_043_044_045;
    v[1].n_exp = 14; v[1].exps = 112'h00_02_14_11_14_12_14_13_14_14_0C_00_14_15;
    v[2].n_in = 7; v[2].ins = 84'h041_042_101_043_044_045_046;
    v[2].n_exp = 16; v[2].exps = 128'h14_11_14_12_00_01_14_13_14_14_14_15_14_16_0C_00;
    v[3].n_in = 9; v[3].ins = 108'h102_041_042_043_044_045_046_047_048;
    v[3].n_exp = 22; v[3].exps = 176'h00_02_14_11_14_12_14_13_14_14_0C_00_14_15_14_16_14_17_14_18_08_00;
    v[4].n_in = 5; v[4].ins = 60'h10E_057_058_059_05A;
    v[4].n_exp = 12; v[4].exps = 96'h00_0E_15_17_15_18_15_19_15_1A_0C_00;

    repeat (3) @(negedge clk);
    #1 chk_reset("por");
    do_reset();
    chk("ready_pre", in_ready, 0);
    @(negedge clk);
    #1 chk("ready_post", in_ready, 1);
    check_init(1);

    for (int k = 0; k < 5; k++) begin
      cap.delete();
      rise.delete();
      for (int i = 0; i < v[k].n_in; i++) push_byte(v[k].ins[12 * (v[k].n_in - 1 - i) +: 12]);
      in_valid = 0;
      wait_idle();
      chk($sformatf("vec%0d_count", k), cap.size(), v[k].n_exp);
      check_seq($sformatf("vec%0d", k), 0, v[k].n_exp, v[k].exps);
    end

    // five bytes offered during init: the fifth must wait for the first pop
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(12'h061 + 12'(i));
    chk("bp_level", fifo_level, 4);
    chk("bp_ready", in_ready, 0);
    push_byte(12'h065);
    chk("bp_fifth_after_pop", cap.size(), 7);
    in_valid = 0;
    check_init(0);
    wait_idle();
    chk("bp_count", cap.size(), 18);
    check_seq("bp", 6, 12, 96'h16_11_16_12_16_13_16_14_0C_00_16_15);

    // reset while lcd_e is high aborts the strobe and drops queued bytes
    for (int i = 0; i < 3; i++) push_byte(12'h041 + 12'(i));
    in_valid = 0;
    for (int t = 0; t < 100 && !lcd_e; t++) begin @(negedge clk); #1; end
    chk("abort_e_seen", lcd_e, 1);
    #2 rst_n = 0;
    #1 chk_reset("abort");
    do_reset();
    check_init(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
